gray_window_3x3: RTL and testbench
==================================

# gray_window_3x3

Streaming 3x3 neighbourhood generator placed directly downstream of the RGB-to-gray converter in the camera filter pipeline. It accepts one 8-bit gray pixel per valid cycle in raster order, buffers the two previous lines, and emits a full 3x3 window for every interior pixel position. Filter kernels (median, Sobel, mean) consume these windows.

## Interface
- IMG_WIDTH, 640, active pixels per line (>= 3)
- IMG_HEIGHT, 480, active lines per frame (>= 3)
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- gray_data  in  8  gray pixel from the converter
- gray_valid  in  1  gray_data carries a pixel this cycle
- gray_sof  in  1  first pixel of frame; sampled only when gray_valid=1
- win_p00..win_p22  out  8 each  window pixels, pRC = row R (0 = oldest line), column C (0 = oldest column); win_p22 = newest pixel
- win_valid  out  1  window outputs hold a new window this cycle (1-cycle pulse)
- win_sof  out  1  qualifies first window of frame (with win_valid)
- win_eof  out  1  qualifies last window of frame (with win_valid)
- busy  out  1  high in ACTIVE state

## Operation
- States: IDLE (wait for frame), ACTIVE (accepting pixels), DONE (frame complete, ignore pixels).
- IDLE -> ACTIVE on gray_valid & gray_sof; that pixel is (row 0, col 0).
- ACTIVE: each valid pixel advances col; col IMG_WIDTH-1 wraps to 0 and increments row. Valid pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) -> DONE.
- DONE: valid pixels without sof ignored (no writes, no windows); gray_valid & gray_sof -> ACTIVE at (0,0).
- gray_sof during ACTIVE: restart at (0,0) on that pixel; partial frame abandoned, no win_eof emitted for it.
- Line buffers: two memories, depth IMG_WIDTH, 8 bits, asynchronous read, synchronous write at address col. On valid pixel: lb1 read -> top row tap, lb0 read -> middle row tap, write lb1 <= lb0 old value, lb0 <= gray_data (read-before-write).
- Three 3-stage column shift registers (top, middle, bottom) shift only on accepted pixels; gray_valid=0 cycles leave all state unchanged.
- Window emitted for pixel (r,c) iff r >= 2 and c >= 2; window covers rows r-2..r, cols c-2..c. Output frame is (IMG_WIDTH-2) x (IMG_HEIGHT-2) windows.
- win_sof with window at (2,2); win_eof with window at (IMG_HEIGHT-1, IMG_WIDTH-1).
- Stale line-buffer contents after restart never reach outputs: row < 2 suppresses win_valid.
- No back-pressure; downstream must accept one window per cycle.

## Timing
- Latency: win_valid one clk after the accepting gray_valid edge for pixel (r,c), window outputs registered.
- Window data holds last value between pulses.
- Reset: state IDLE, row=col=0, shift registers 0, all win_p* = 0, win_valid=win_sof=win_eof=0, busy=0. Line buffer contents not reset.
- Reset mid-frame: returns to IDLE immediately; next frame needs gray_sof.
- Counter widths: $clog2(IMG_WIDTH), $clog2(IMG_HEIGHT).

## Structure
- Shared package camera_filter_pkg: PIX_W=8, window type (3x3 array of PIX_W), state enum IDLE/ACTIVE/DONE.
- Sub-module gray_line_buffer: parameterised depth/width, async read, sync write with enable; instantiated twice.

## Test plan
- IMG_WIDTH=8, IMG_HEIGHT=6, continuous valid, pixel value = 8*row+col, sof on first -> 24 win_valid pulses; first window win_p00=0, win_p22=18, win_sof=1; last window win_p22=47, win_eof=1; busy drops after pixel 47.
- Same frame with gray_valid toggling 1-0-1 -> identical window sequence, pulses only one cycle after valid pixels.
- Extra 5 valid pixels after frame without sof -> no win_valid, state DONE; then sof frame -> normal 24 windows.
- sof reissued at pixel (3,4) mid-frame -> no win_eof for aborted frame; new frame yields 24 windows, first win_sof window p00=0 of new data.
- rst_n asserted at (4,5) mid-frame -> all outputs 0 same cycle; valid pixels without sof ignored; next sof frame correct.
- gray_valid=0 throughout with gray_sof=1 toggling -> stays IDLE, no outputs.

Source files
------------

// File: rtl/camera_filter_pkg.sv
// Shared types for the camera filter pipeline: pixel width, 3x3 window
// layout and the frame-tracking state encoding.
package camera_filter_pkg;

  localparam int PIX_W = 8;

  // Indexing is [row][col]; row 0 is the oldest line, col 0 the oldest column.
  typedef logic [0:2][PIX_W-1:0]        taps_t;
  typedef logic [0:2][0:2][PIX_W-1:0]   window_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/gray_window_3x3_if.sv
// Pixel-in / window-out bundle for gray_window_3x3.
interface gray_window_3x3_if;
  import camera_filter_pkg::*;

  // Valid-only streams, no ready: a pixel is taken on every clk edge with
  // gray_valid=1, and each window is a single-cycle win_valid pulse that the
  // consumer must take on that edge. gray_sof/win_sof/win_eof are meaningful
  // only while their valid is high.
  logic [PIX_W-1:0] gray_data;
  logic             gray_valid;
  logic             gray_sof;

  logic [PIX_W-1:0] win_p00, win_p01, win_p02;
  logic [PIX_W-1:0] win_p10, win_p11, win_p12;
  logic [PIX_W-1:0] win_p20, win_p21, win_p22;
  logic             win_valid;
  logic             win_sof;
  logic             win_eof;
  logic             busy;

  modport slave (
    input  gray_data, gray_valid, gray_sof,
    output win_p00, win_p01, win_p02,
    output win_p10, win_p11, win_p12,
    output win_p20, win_p21, win_p22,
    output win_valid, win_sof, win_eof, busy
  );

  modport master (
    output gray_data, gray_valid, gray_sof,
    input  win_p00, win_p01, win_p02,
    input  win_p10, win_p11, win_p12,
    input  win_p20, win_p21, win_p22,
    input  win_valid, win_sof, win_eof, busy
  );

endinterface

// File: rtl/gray_line_buffer.sv
// One line of pixel storage: asynchronous read, synchronous write with enable.
module gray_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  // Contents are deliberately not reset; stale data is masked downstream.
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

endmodule

// File: rtl/gray_window_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus three 3-deep
// column shift registers, emitting one registered window per interior pixel.
module gray_window_3x3
  import camera_filter_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  gray_window_3x3_if.slave   bus,
  output state_e             dbg_state
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  taps_t           top_q, top_d, mid_q, mid_d, bot_q, bot_d;
  window_t         win_q, win_d;
  logic            win_valid_q, win_valid_d;
  logic            win_sof_q, win_sof_d;
  logic            win_eof_q, win_eof_d;

  logic            accept;
  logic [RW-1:0]   pix_row;
  logic [CW-1:0]   pix_col;
  logic            last_col, last_row;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;

  gray_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (pix_col),
    .wdata (bus.gray_data),
    .rdata (lb0_rd)
  );

  // lb1 takes lb0's old value at the same address: read-before-write cascade.
  gray_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (pix_col),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    top_d       = top_q;
    mid_d       = mid_q;
    bot_d       = bot_q;
    win_d       = win_q;
    win_valid_d = 1'b0;
    win_sof_d   = 1'b0;
    win_eof_d   = 1'b0;

    // sof restarts at (0,0) from any state; otherwise only ACTIVE takes pixels.
    accept  = bus.gray_valid && (bus.gray_sof || (state_q == ACTIVE));
    pix_row = bus.gray_sof ? '0 : row_q;
    pix_col = bus.gray_sof ? '0 : col_q;
    last_col = (pix_col == COL_LAST);
    last_row = (pix_row == ROW_LAST);

    if (accept) begin
      top_d[0] = top_q[1];
      top_d[1] = top_q[2];
      top_d[2] = lb1_rd;
      mid_d[0] = mid_q[1];
      mid_d[1] = mid_q[2];
      mid_d[2] = lb0_rd;
      bot_d[0] = bot_q[1];
      bot_d[1] = bot_q[2];
      bot_d[2] = bus.gray_data;

      state_d = ACTIVE;
      if (last_col) begin
        col_d = '0;
        row_d = pix_row + RW'(1);
      end else begin
        col_d = pix_col + CW'(1);
        row_d = pix_row;
      end
      if (last_col && last_row) begin
        state_d = DONE;
        row_d   = '0;
        col_d   = '0;
      end

      // Rows 0/1 would expose stale line-buffer data, so they never emit.
      if ((pix_row >= RW'(2)) && (pix_col >= CW'(2))) begin
        win_valid_d = 1'b1;
        win_d[0]    = top_d;
        win_d[1]    = mid_d;
        win_d[2]    = bot_d;
        win_sof_d   = (pix_row == RW'(2)) && (pix_col == CW'(2));
        win_eof_d   = last_col && last_row;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      top_q       <= '0;
      mid_q       <= '0;
      bot_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_sof_q   <= 1'b0;
      win_eof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      top_q       <= top_d;
      mid_q       <= mid_d;
      bot_q       <= bot_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_sof_q   <= win_sof_d;
      win_eof_q   <= win_eof_d;
    end
  end

  assign bus.win_p00   = win_q[0][0];
  assign bus.win_p01   = win_q[0][1];
  assign bus.win_p02   = win_q[0][2];
  assign bus.win_p10   = win_q[1][0];
  assign bus.win_p11   = win_q[1][1];
  assign bus.win_p12   = win_q[1][2];
  assign bus.win_p20   = win_q[2][0];
  assign bus.win_p21   = win_q[2][1];
  assign bus.win_p22   = win_q[2][2];
  assign bus.win_valid = win_valid_q;
  assign bus.win_sof   = win_sof_q;
  assign bus.win_eof   = win_eof_q;
  assign bus.busy      = (state_q == ACTIVE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_gray_window_3x3.sv
// Directed bench for gray_window_3x3 on an 8x6 frame; expected windows are
// queued by the driver and checked by an independent monitor.
module tb_gray_window_3x3;
  import camera_filter_pkg::*;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int EW = 74;  // {sof, eof, p00..p22}

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_e dbg_state;

  gray_window_3x3_if bus ();

  gray_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            win_cnt = 0;
  int            eof_cnt = 0;
  logic [7:0]    first_p00 = 8'hFF;
  logic [7:0]    first_p22 = 8'hFF;
  logic [7:0]    last_p22  = 8'hFF;
  logic          prev_valid = 1'b0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] act_word();
    return {bus.win_sof, bus.win_eof,
            bus.win_p00, bus.win_p01, bus.win_p02,
            bus.win_p10, bus.win_p11, bus.win_p12,
            bus.win_p20, bus.win_p21, bus.win_p22};
  endfunction

  // Frame pixel value is base + 8*row + col; window at (r,c) spans r-2..r, c-2..c.
  function automatic logic [EW-1:0] exp_win(input int base, input int r, input int c);
    logic [EW-1:0] w;
    w     = '0;
    w[73] = (r == 2) && (c == 2);
    w[72] = (r == H - 1) && (c == W - 1);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w[71 - 8 * (3 * i + j) -: 8] = 8'(base + 8 * (r - 2 + i) + (c - 2 + j));
      end
    end
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    @(posedge clk);
    #1;
    bus.gray_valid = v;
    bus.gray_sof   = s;
    bus.gray_data  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h5A);
  endtask

  // Sends a frame in raster order, stopping before (stop_r, stop_c).
  task automatic send_frame(input int base, input bit gap, input int stop_r, input int stop_c);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == stop_r && c == stop_c) return;
        drive(1'b1, (r == 0 && c == 0), 8'(base + 8 * r + c));
        if (r == 0 && c == 1) check("busy_in_frame", EW'(bus.busy), EW'(1));
        if (r >= 2 && c >= 2) exp_q.push_back(exp_win(base, r, c));
        if (gap) drive(1'b0, 1'b0, 8'hA5);
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) prev_valid <= bus.gray_valid;

  always @(negedge clk) begin
    if (rst_n && bus.win_valid) begin
      logic [EW-1:0] a;
      a = act_word();
      win_cnt++;
      check("pulse_follows_valid_pixel", EW'(prev_valid), EW'(1));
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_window: got %h expected none", a);
      end else begin
        check("window", a, exp_q.pop_front());
      end
      if (bus.win_sof) begin
        first_p00 = bus.win_p00;
        first_p22 = bus.win_p22;
      end
      if (bus.win_eof) begin
        eof_cnt++;
        last_p22 = bus.win_p22;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int saved;
    bus.gray_valid = 1'b0;
    bus.gray_sof   = 1'b0;
    bus.gray_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_window", act_word(), '0);
    check("reset_win_valid", EW'(bus.win_valid), EW'(0));
    check("reset_busy", EW'(bus.busy), EW'(0));
    check("reset_state", EW'(dbg_state), EW'(IDLE));
    rst_n = 1'b1;

    // sof toggling without valid must not start a frame
    for (int i = 0; i < 6; i++) drive(1'b0, 1'(i % 2), 8'h33);
    idle(2);
    check("idle_sof_state", EW'(dbg_state), EW'(IDLE));
    check("idle_sof_busy", EW'(bus.busy), EW'(0));
    check("idle_sof_no_windows", EW'(win_cnt), EW'(0));

    // continuous frame
    win_cnt = 0; eof_cnt = 0;
    send_frame(0, 1'b0, H, 0);
    idle(2);
    check("f1_count", EW'(win_cnt), EW'(24));
    check("f1_eof_count", EW'(eof_cnt), EW'(1));
    check("f1_first_p00", EW'(first_p00), EW'(0));
    check("f1_first_p22", EW'(first_p22), EW'(18));
    check("f1_last_p22", EW'(last_p22), EW'(47));
    check("f1_busy_after", EW'(bus.busy), EW'(0));
    check("f1_state_done", EW'(dbg_state), EW'(DONE));
    check("f1_queue_empty", EW'(exp_q.size()), EW'(0));

    // same frame with valid toggling 1-0-1
    win_cnt = 0; eof_cnt = 0;
    send_frame(0, 1'b1, H, 0);
    idle(2);
    check("gap_count", EW'(win_cnt), EW'(24));
    check("gap_eof_count", EW'(eof_cnt), EW'(1));
    check("gap_queue_empty", EW'(exp_q.size()), EW'(0));

    // pixels without sof after the frame are ignored
    win_cnt = 0;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'(200 + i));
    idle(2);
    check("done_ignore_count", EW'(win_cnt), EW'(0));
    check("done_ignore_state", EW'(dbg_state), EW'(DONE));
    win_cnt = 0; eof_cnt = 0;
    send_frame(50, 1'b0, H, 0);
    idle(2);
    check("after_done_count", EW'(win_cnt), EW'(24));
    check("after_done_eof", EW'(eof_cnt), EW'(1));

    // sof reissued at (3,4): 8 windows of the aborted frame, 24 of the new one
    win_cnt = 0; eof_cnt = 0; first_p00 = 8'hFF;
    send_frame(100, 1'b0, 3, 4);
    send_frame(0, 1'b0, H, 0);
    idle(2);
    check("restart_count", EW'(win_cnt), EW'(32));
    check("restart_eof_count", EW'(eof_cnt), EW'(1));
    check("restart_first_p00", EW'(first_p00), EW'(0));
    check("restart_queue_empty", EW'(exp_q.size()), EW'(0));

    // reset asserted when (4,5) is next
    win_cnt = 0; eof_cnt = 0;
    send_frame(20, 1'b0, 4, 5);
    idle(1);
    @(negedge clk);
    #1;
    check("pre_reset_count", EW'(win_cnt), EW'(15));
    check("pre_reset_window", act_word(), exp_win(20, 4, 4));
    rst_n = 1'b0;
    #1;
    check("midreset_window", act_word(), '0);
    check("midreset_win_valid", EW'(bus.win_valid), EW'(0));
    check("midreset_busy", EW'(bus.busy), EW'(0));
    check("midreset_state", EW'(dbg_state), EW'(IDLE));
    check("midreset_queue_empty", EW'(exp_q.size()), EW'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    saved = win_cnt;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'(150 + i));
    idle(2);
    check("postreset_ignore_count", EW'(win_cnt - saved), EW'(0));
    check("postreset_state", EW'(dbg_state), EW'(IDLE));
    win_cnt = 0; eof_cnt = 0;
    send_frame(7, 1'b0, H, 0);
    idle(2);
    check("postreset_frame_count", EW'(win_cnt), EW'(24));
    check("postreset_frame_eof", EW'(eof_cnt), EW'(1));
    check("postreset_queue_empty", EW'(exp_q.size()), EW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
